// File: rtl/z80_bus_arbiter.sv
// Registered three-master arbiter (m0 VGA > m1 UART > m2 CPU) for the Z80 system bus.
// Optional hung-transaction abort with bus-error pulse enabled by defining ARB_TIMEOUT_EN.
module z80_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m2_addr,
  input  logic [7:0]  i_m0_dat,
  input  logic [7:0]  i_m1_dat,
  input  logic [7:0]  i_m2_dat,
  input  logic        i_m0_we,
  input  logic        i_m1_we,
  input  logic        i_m2_we,
  input  logic        i_m0_cs,
  input  logic        i_m1_cs,
  input  logic        i_m2_cs,
  output logic        o_m0_ack,
  output logic        o_m1_ack,
  output logic        o_m2_ack,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dat,
  output logic        o_we,
  output logic        o_cs,
  input  logic        i_ack,
  output logic [2:0]  o_grant,
  output logic        o_bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] req;
  logic       busy;
  logic       gcs;
  logic       to_hit;
  logic       ack_ok;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign req  = {i_m2_cs, i_m1_cs, i_m0_cs};
  assign busy = (state_q == BUSY);
  assign gcs  = |(grant_q & req);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;

  // Counter is held at zero in IDLE, so every BUSY entry starts from 0.
  always_ff @(posedge i_clk) begin
    if (i_reset || !busy) begin
      cnt_q <= '0;
    end else if (!i_ack) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign to_hit = busy & gcs & ~i_ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          if (req[0])      grant_d = 3'b001;
          else if (req[1]) grant_d = 3'b010;
          else             grant_d = 3'b100;
        end
      end
      BUSY: begin
        if (!gcs || i_ack || to_hit) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    o_addr = '0;
    o_dat  = '0;
    o_we   = 1'b0;
    o_cs   = 1'b0;
    if (busy) begin
      o_addr = ({16{grant_q[0]}} & i_m0_addr) |
               ({16{grant_q[1]}} & i_m1_addr) |
               ({16{grant_q[2]}} & i_m2_addr);
      o_dat  = ({8{grant_q[0]}} & i_m0_dat) |
               ({8{grant_q[1]}} & i_m1_dat) |
               ({8{grant_q[2]}} & i_m2_dat);
      o_we   = (grant_q[0] & i_m0_we) | (grant_q[1] & i_m1_we) | (grant_q[2] & i_m2_we);
      o_cs   = gcs;
    end
  end

  // A timeout completes the transaction toward the master like an ack does.
  assign ack_ok    = busy & gcs & ~i_reset & (i_ack | to_hit);
  assign o_m0_ack  = ack_ok & grant_q[0];
  assign o_m1_ack  = ack_ok & grant_q[1];
  assign o_m2_ack  = ack_ok & grant_q[2];
  assign o_bus_err = busy & ~i_reset & to_hit;
  assign o_grant   = grant_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed vector bench for z80_bus_arbiter: one vector per clock cycle, outputs
// compared mid-cycle; timeout behaviour checked in both ARB_TIMEOUT_EN builds.
module tb_z80_bus_arbiter;

  localparam logic [15:0] A0 = 16'hA0A0, A1 = 16'h8000, A2 = 16'h1234;
  localparam logic [7:0]  D0 = 8'h11,    D1 = 8'h55,    D2 = 8'h22;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cs, we;
  logic        ack;
  logic [15:0] o_addr;
  logic [7:0]  o_dat;
  logic        o_we, o_cs, o_bus_err;
  logic        m0_ack, m1_ack, m2_ack;
  logic [2:0]  o_grant;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  z80_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_addr(A0), .i_m1_addr(A1), .i_m2_addr(A2),
    .i_m0_dat(D0), .i_m1_dat(D1), .i_m2_dat(D2),
    .i_m0_we(we[0]), .i_m1_we(we[1]), .i_m2_we(we[2]),
    .i_m0_cs(cs[0]), .i_m1_cs(cs[1]), .i_m2_cs(cs[2]),
    .o_m0_ack(m0_ack), .o_m1_ack(m1_ack), .o_m2_ack(m2_ack),
    .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs),
    .i_ack(ack), .o_grant(o_grant), .o_bus_err(o_bus_err)
  );

  typedef struct {
    logic       rst;
    logic [2:0] cs;
    logic [2:0] we;
    logic       ack;
    logic [2:0] g;
    logic       ocs;
    logic [2:0] acks;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] c, input logic [2:0] w, input logic a,
                     input logic [2:0] g, input logic oc, input logic [2:0] ak, input logic e);
    vec_t v;
    v.rst = r; v.cs = c; v.we = w; v.ack = a; v.g = g; v.ocs = oc; v.acks = ak; v.err = e;
    vecs.push_back(v);
  endtask

  // Applies inputs just after the rising edge and compares in the low phase.
  task automatic run_vec(input string name, input vec_t v);
    logic [32:0] act, exp;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew;
    @(posedge clk);
    #1;
    rst = v.rst; cs = v.cs; we = v.we; ack = v.ack;
    @(negedge clk);
    ea = v.g[0] ? A0 : v.g[1] ? A1 : v.g[2] ? A2 : 16'h0000;
    ed = v.g[0] ? D0 : v.g[1] ? D1 : v.g[2] ? D2 : 8'h00;
    ew = |(v.g & v.we);
    exp = {v.g, v.ocs, ew, ea, ed, v.acks, v.err};
    act = {o_grant, o_cs, o_we, o_addr, o_dat, m2_ack, m1_ack, m0_ack, o_bus_err};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got grant=%b cs=%b we=%b addr=%h dat=%h acks=%b err=%b, want grant=%b cs=%b we=%b addr=%h dat=%h acks=%b err=%b",
               name, act[32:30], act[29], act[28], act[27:12], act[11:4], act[3:1], act[0],
               exp[32:30], exp[29], exp[28], exp[27:12], exp[11:4], exp[3:1], exp[0]);
    end
  endtask

  initial begin
    vec_t v;
    bit   stray;
    rst = 1'b1; cs = '0; we = '0; ack = 1'b0;
    repeat (2) @(posedge clk);

    //   rst cs      we      ack g       ocs acks    err
    add(1, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0); // reset state
    // single read by m2, zero-wait slave
    add(0, 3'b100, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b100, 3'b000, 1, 3'b100, 1, 3'b100, 0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    // simultaneous m1 write / m2 read
    add(0, 3'b110, 3'b010, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b110, 3'b010, 0, 3'b010, 1, 3'b000, 0);
    add(0, 3'b110, 3'b010, 1, 3'b010, 1, 3'b010, 0);
    add(0, 3'b100, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b100, 3'b000, 1, 3'b100, 1, 3'b100, 0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    // m0 read with wait states, m1 requesting meanwhile
    add(0, 3'b001, 3'b010, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b011, 3'b010, 0, 3'b001, 1, 3'b000, 0);
    add(0, 3'b011, 3'b010, 0, 3'b001, 1, 3'b000, 0);
    add(0, 3'b011, 3'b010, 0, 3'b001, 1, 3'b000, 0);
    add(0, 3'b011, 3'b010, 0, 3'b001, 1, 3'b000, 0);
    add(0, 3'b011, 3'b010, 1, 3'b001, 1, 3'b001, 0);
    add(0, 3'b010, 3'b010, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b010, 3'b010, 0, 3'b010, 1, 3'b000, 0);
    add(0, 3'b010, 3'b010, 1, 3'b010, 1, 3'b010, 0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    // abort: m2 drops cs before ack; late ack must not reach anyone
    add(0, 3'b100, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b100, 3'b000, 0, 3'b100, 1, 3'b000, 0);
    add(0, 3'b100, 3'b000, 0, 3'b100, 1, 3'b000, 0);
    add(0, 3'b000, 3'b000, 1, 3'b100, 0, 3'b000, 0);
    add(0, 3'b000, 3'b000, 1, 3'b000, 0, 3'b000, 0);
    // reset while BUSY with ack high
    add(0, 3'b001, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 0, 3'b001, 1, 3'b000, 0);
    add(1, 3'b001, 3'b000, 1, 3'b001, 1, 3'b000, 0);
    add(0, 3'b001, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b001, 3'b000, 1, 3'b001, 1, 3'b001, 0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    // all three requesting: strict priority, one IDLE gap between owners
    add(0, 3'b111, 3'b110, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b111, 3'b110, 1, 3'b001, 1, 3'b001, 0);
    add(0, 3'b110, 3'b110, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b110, 3'b110, 1, 3'b010, 1, 3'b010, 0);
    add(0, 3'b100, 3'b100, 0, 3'b000, 0, 3'b000, 0);
    add(0, 3'b100, 3'b100, 1, 3'b100, 1, 3'b100, 0);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Hung slave on an m1 write.
    v.rst = 0; v.we = 3'b010; v.ack = 0; v.err = 0;
    v.cs = 3'b010; v.g = 3'b000; v.ocs = 0; v.acks = 3'b000;
    run_vec("hang_req", v);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      v.g = 3'b010; v.ocs = 1;
      v.acks = (k == 4) ? 3'b010 : 3'b000;
      v.err  = (k == 4);
      run_vec($sformatf("timeout_busy%0d", k), v);
    end
    v.cs = 3'b000; v.g = 3'b000; v.ocs = 0; v.acks = 3'b000; v.err = 0;
    run_vec("timeout_idle", v);
`else
    stray = 1'b0;
    for (int k = 0; k < 305; k++) begin
      @(negedge clk);
      if (o_grant !== 3'b010 || o_cs !== 1'b1 || m1_ack !== 1'b0 || o_bus_err !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_bad++;
      $display("FAIL hang_hold: BUSY left or ack/err seen within 305 cycles, want steady grant=010 no ack");
    end
    v.g = 3'b010; v.ocs = 1; v.ack = 1; v.acks = 3'b010;
    run_vec("hang_late_ack", v);
    v.cs = 3'b000; v.ack = 0; v.g = 3'b000; v.ocs = 0; v.acks = 3'b000;
    run_vec("hang_idle", v);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
